// File: rtl/wb_queue.sv
// Purpose: in-order register write-back queue with two combinational forwarding lookup ports.
// Latency: an accepted write reaches the write port in the cycle after it is pushed; lookups take zero cycles.
// Backpressure: reqReady drops only when all DEPTH entries are full; wbStall holds every queued entry in place.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reqValid,
    input  logic [4:0]               reqAddr,
    input  logic [31:0]              reqData,
    output logic                     reqReady,
    input  logic                     wbStall,
    input  logic                     flush,
    output logic [4:0]               addr3,
    output logic [31:0]              din,
    output logic                     regWrite,
    input  logic [4:0]               fwdAddr1,
    input  logic [4:0]               fwdAddr2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [31:0]              fwdData1,
    output logic [31:0]              fwdData2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [4:0]  mem_addr_q [DEPTH];
    logic [31:0] mem_data_q [DEPTH];

    logic push;
    logic pop;

    // Handshake and write-port outputs; regWrite is also held off while reset
    // is asserted so that no write escapes from a queue that is being discarded.
    always_comb begin
        reqReady = (count_q != FULL);
        push     = reqValid && reqReady && !flush && (reqAddr != 5'd0);
        regWrite = rst && (count_q != '0) && !wbStall && !flush;
        pop      = regWrite;
        addr3    = '0;
        din      = '0;
        if (count_q != '0) begin
            addr3 = mem_addr_q[head_q];
            din   = mem_data_q[head_q];
        end
    end

    // Pointer and occupancy next-state; flush empties the queue outright.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_addr_q[tail_q] <= reqAddr;
            mem_data_q[tail_q] <= reqData;
        end
    end

    // Forwarding: walk live entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx      = '0;
        fwdHit1  = 1'b0;
        fwdHit2  = 1'b0;
        fwdData1 = '0;
        fwdData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < count_q) begin
                if ((fwdAddr1 != 5'd0) && (mem_addr_q[idx] == fwdAddr1)) begin
                    fwdHit1  = 1'b1;
                    fwdData1 = mem_data_q[idx];
                end
                if ((fwdAddr2 != 5'd0) && (mem_addr_q[idx] == fwdAddr2)) begin
                    fwdHit2  = 1'b1;
                    fwdData2 = mem_data_q[idx];
                end
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic [4:0]  reqAddr;
    logic [31:0] reqData;
    logic        reqReady;
    logic        wbStall;
    logic        flush;
    logic [4:0]  addr3;
    logic [31:0] din;
    logic        regWrite;
    logic [4:0]  fwdAddr1, fwdAddr2;
    logic        fwdHit1, fwdHit2;
    logic [31:0] fwdData1, fwdData2;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] sb [$];

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData), .reqReady(reqReady),
        .wbStall(wbStall), .flush(flush),
        .addr3(addr3), .din(din), .regWrite(regWrite),
        .fwdAddr1(fwdAddr1), .fwdAddr2(fwdAddr2),
        .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
        .fwdData1(fwdData1), .fwdData2(fwdData2),
        .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write-port pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (regWrite === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_unexpected: got addr %0d data 0x%08h expected no write", addr3, din);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(addr3), 32'(e[36:32]));
                chk("wr_data", din, e[31:0]);
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic st, input logic fl);
        @(posedge clk);
        #1;
        reqValid = v;
        reqAddr  = a;
        reqData  = d;
        wbStall  = st;
        flush    = fl;
    endtask

    task automatic idle(input logic st);
        drive(1'b0, 5'd0, 32'd0, st, 1'b0);
    endtask

    // Holds an offer until it is accepted; accepted non-zero writes are expected at the port.
    task automatic offer(input logic [4:0] a, input logic [31:0] d, input logic st);
        int tries = 0;
        drive(1'b1, a, d, st, 1'b0);
        while (reqReady !== 1'b1 && tries < 20) begin
            tries++;
            drive(1'b1, a, d, 1'b0, 1'b0);
        end
        if (reqReady !== 1'b1) begin
            chk("offer_timeout", 32'(reqReady), 32'd1);
        end else if (a != 5'd0) begin
            sb.push_back({a, d});
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_reqReady"}, 32'(reqReady), 32'd1);
        chk({tag, "_regWrite"}, 32'(regWrite), 32'd0);
        chk({tag, "_addr3"}, 32'(addr3), 32'd0);
        chk({tag, "_din"}, din, 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_fwdHit1"}, 32'(fwdHit1), 32'd0);
        chk({tag, "_fwdData1"}, fwdData1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; reqValid = 1'b0; reqAddr = '0; reqData = '0;
        wbStall = 1'b0; flush = 1'b0; fwdAddr1 = 5'd1; fwdAddr2 = 5'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_fwdHit2", 32'(fwdHit2), 32'd0);
        chk("reset_fwdData2", fwdData2, 32'd0);
        rst = 1'b1;

        // Single write appears the cycle after the push, then the queue is empty.
        offer(5'd1, 32'h1111_1111, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("t1_regWrite", 32'(regWrite), 32'd1);
        chk("t1_addr3", 32'(addr3), 32'd1);
        chk("t1_din", din, 32'h1111_1111);
        idle(1'b0);
        @(negedge clk);
        chk("t1_regWrite_after", 32'(regWrite), 32'd0);
        chk("t1_count_after", 32'(count), 32'd0);

        // Fill under stall; fifth offer refused; release drains in order.
        for (int i = 2; i <= 5; i++) offer(5'(i), 32'hA0 + 32'(i), 1'b1);
        drive(1'b1, 5'd6, 32'hA6, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_reqReady_full", 32'(reqReady), 32'd0);
        chk("t2_regWrite_stall", 32'(regWrite), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            @(negedge clk);
            chk("t2_drain_regWrite", 32'(regWrite), 32'd1);
            chk("t2_drain_count", 32'(count), 32'(4 - i));
        end
        idle(1'b0);
        @(negedge clk);
        chk("t2_empty_count", 32'(count), 32'd0);

        // Forwarding picks the youngest match and ignores the same-cycle offer.
        offer(5'd5, 32'hAAAA_AAAA, 1'b1);
        offer(5'd5, 32'hBBBB_BBBB, 1'b1);
        fwdAddr1 = 5'd5;
        fwdAddr2 = 5'd6;
        offer(5'd6, 32'hCCCC_CCCC, 1'b1);
        @(negedge clk);
        chk("t3_fwdHit1", 32'(fwdHit1), 32'd1);
        chk("t3_fwdData1", fwdData1, 32'hBBBB_BBBB);
        chk("t3_fwdHit2_offer", 32'(fwdHit2), 32'd0);
        chk("t3_fwdData2_offer", fwdData2, 32'd0);
        idle(1'b1);
        @(negedge clk);
        chk("t3_fwdHit2_stored", 32'(fwdHit2), 32'd1);
        chk("t3_fwdData2_stored", fwdData2, 32'hCCCC_CCCC);
        idle(1'b0);
        @(negedge clk);
        chk("t3_pop_head_fwd1", fwdData1, 32'hBBBB_BBBB);
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("t3_last_count", 32'(count), 32'd1);
        chk("t3_head_pop_fwdHit2", 32'(fwdHit2), 32'd1);
        chk("t3_head_pop_fwdData2", fwdData2, 32'hCCCC_CCCC);
        idle(1'b0);

        // Address zero is accepted but never stored.
        fwdAddr1 = 5'd0;
        fwdAddr2 = 5'd0;
        drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_reqReady", 32'(reqReady), 32'd1);
        chk("t4_fwdHit1", 32'(fwdHit1), 32'd0);
        idle(1'b0);
        @(negedge clk);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_regWrite", 32'(regWrite), 32'd0);

        // Flush discards three stalled entries and a concurrent offer.
        fwdAddr1 = 5'd7;
        for (int i = 7; i <= 9; i++) drive(1'b1, 5'(i), 32'hF0 + 32'(i), 1'b1, 1'b0);
        drive(1'b1, 5'd10, 32'hFA, 1'b1, 1'b1);
        @(negedge clk);
        chk("t5_flush_reqReady", 32'(reqReady), 32'd1);
        chk("t5_flush_regWrite", 32'(regWrite), 32'd0);
        idle(1'b0);
        @(negedge clk);
        chk_idle_outputs("t5_flush");
        idle(1'b0);
        @(negedge clk);
        chk("t5_flush_regWrite2", 32'(regWrite), 32'd0);

        // Reset mid-operation, with stall released in the same cycle.
        for (int i = 7; i <= 9; i++) drive(1'b1, 5'(i), 32'hE0 + 32'(i), 1'b1, 1'b0);
        idle(1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_regWrite", 32'(regWrite), 32'd0);
        idle(1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t5_rst");

        // Full queue: pop frees a slot but the push waits one cycle.
        for (int i = 11; i <= 14; i++) offer(5'(i), 32'hD0 + 32'(i), 1'b1);
        drive(1'b1, 5'd15, 32'hDF, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_full_reqReady", 32'(reqReady), 32'd0);
        chk("t6_full_regWrite", 32'(regWrite), 32'd1);
        drive(1'b1, 5'd15, 32'hDF, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_count3", 32'(count), 32'd3);
        chk("t6_reqReady", 32'(reqReady), 32'd1);
        sb.push_back({5'd15, 32'hDF});
        idle(1'b0);
        @(negedge clk);
        chk("t6_count_after_push", 32'(count), 32'd3);

        // Pointer wrap: 3*DEPTH writes with an intermittent stall, all in order.
        for (int k = 0; k < 3 * DEPTH; k++) begin
            offer(5'(16 + k), 32'hC000_0000 + 32'(k), (k % 3) == 0);
        end
        begin
            int guard = 0;
            idle(1'b0);
            while (count != 0 && guard < 30) begin
                guard++;
                idle(1'b0);
            end
        end
        @(negedge clk);
        chk("t6_wrap_count", 32'(count), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
